// File: rtl/keypad_entry_buffer.sv
// keypad_entry_buffer
//   Turns the decoded key stream of the 4x4 keypad scanner into BCD numbers.
//   Digits 0-9 are shifted into a live entry buffer (newest digit in the low
//   nibble). C is backspace, E (*) is clear, F (#) commits the entry. A
//   committed number is offered downstream on a valid/ready interface.
//
//   Ports
//     clk          rising-edge clock
//     reset        asynchronous, active-high reset
//     key_value    decoded key code, valid while key_pressed is high
//     key_pressed  scanner level flag, high from debounce until release
//     out_ready    downstream accepts out_value while out_valid is high
//     out_valid    committed number available
//     out_value    committed BCD number, LS digit in [3:0], unused digits 0
//     entry        live BCD entry buffer for display, same packing
//     digit_count  number of digits currently held in entry
//     key_event    1-cycle pulse per accepted key press (rejected ones too)
//     overflow     1-cycle pulse when a digit is dropped on a full buffer
//     reject       1-cycle pulse on A/B/D, or on an F that cannot commit
//
//   state       | meaning
//   ST_ENTRY    | no number pending; out_valid low, F commits a non-empty entry
//   ST_COMMIT   | out_value offered and held; typing ahead allowed, F rejected
module keypad_entry_buffer #(
  parameter int NUM_DIGITS = 4,
  parameter int CW         = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              key_value,
  input  logic                    key_pressed,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] out_value,
  output logic [4*NUM_DIGITS-1:0] entry,
  output logic [CW-1:0]           digit_count,
  output logic                    key_event,
  output logic                    overflow,
  output logic                    reject
);

  localparam int            EW        = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] FULL      = CW'(NUM_DIGITS);
  localparam logic [3:0]    KEY_BACK  = 4'hC;
  localparam logic [3:0]    KEY_CLEAR = 4'hE;
  localparam logic [3:0]    KEY_ENTER = 4'hF;

  typedef enum logic {
    ST_ENTRY  = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  state_t        state;
  logic          kp_d;
  logic          press;
  logic          is_digit;
  logic [EW-1:0] entry_push;
  logic [EW-1:0] entry_pop;

  always_comb begin
    press      = key_pressed & ~kp_d;
    is_digit   = (key_value <= 4'd9);
    entry_push = (entry << 4) | EW'(key_value);
    entry_pop  = entry >> 4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_ENTRY;
      // Starting high means a key held through reset only counts after a
      // release and a fresh press.
      kp_d        <= 1'b1;
      out_valid   <= 1'b0;
      out_value   <= '0;
      entry       <= '0;
      digit_count <= '0;
      key_event   <= 1'b0;
      overflow    <= 1'b0;
      reject      <= 1'b0;
    end else begin
      kp_d      <= key_pressed;
      key_event <= press;
      overflow  <= 1'b0;
      reject    <= 1'b0;

      // Handshake; out_value deliberately keeps its last value afterwards.
      if (state == ST_COMMIT && out_ready) begin
        out_valid <= 1'b0;
        state     <= ST_ENTRY;
      end

      if (press) begin
        if (is_digit) begin
          if (digit_count < FULL) begin
            entry       <= entry_push;
            digit_count <= digit_count + CW'(1);
          end else begin
            overflow <= 1'b1;
          end
        end else if (key_value == KEY_BACK) begin
          if (digit_count != '0) begin
            entry       <= entry_pop;
            digit_count <= digit_count - CW'(1);
          end
        end else if (key_value == KEY_CLEAR) begin
          entry       <= '0;
          digit_count <= '0;
        end else if (key_value == KEY_ENTER) begin
          // An F coinciding with the handshake still sees ST_COMMIT here
          // and is therefore rejected.
          if (state == ST_ENTRY && digit_count != '0) begin
            out_value   <= entry;
            out_valid   <= 1'b1;
            entry       <= '0;
            digit_count <= '0;
            state       <= ST_COMMIT;
          end else begin
            reject <= 1'b1;
          end
        end else begin
          reject <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// tb_keypad_entry_buffer
//   Directed bench for keypad_entry_buffer (NUM_DIGITS = 4). Inputs change
//   on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_keypad_entry_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_value;
  logic        key_pressed;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_value;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic        key_event;
  logic        overflow;
  logic        reject;

  int n_total  = 0;
  int n_passed = 0;
  int n_failed = 0;

  logic last_ev, last_ov, last_rj;

  keypad_entry_buffer #(.NUM_DIGITS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_value   (key_value),
    .key_pressed (key_pressed),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_value   (out_value),
    .entry       (entry),
    .digit_count (digit_count),
    .key_event   (key_event),
    .overflow    (overflow),
    .reject      (reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else begin
      n_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on a falling edge with kp_d low again.
  task automatic press_key(input logic [3:0] k);
    key_value   = k;
    key_pressed = 1'b1;
    @(posedge clk); #1;
    last_ev = key_event;
    last_ov = overflow;
    last_rj = reject;
    @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    int ev_cnt;
    int rj_cnt;
    int bad;

    reset       = 1'b1;
    key_value   = 4'h0;
    key_pressed = 1'b0;
    out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_entry", entry, 0);
    chk("rst_count", digit_count, 0);
    chk("rst_pulses", {key_event, overflow, reject}, 0);
    reset = 1'b0;
    @(negedge clk);

    // T1 basic entry and commit
    press_key(4'h1);
    chk("t1_ev1", last_ev, 1);
    chk("t1_entry1", entry, 16'h0001);
    press_key(4'h2);
    chk("t1_entry2", entry, 16'h0012);
    press_key(4'h3);
    chk("t1_entry3", entry, 16'h0123);
    chk("t1_count3", digit_count, 3);
    press_key(4'hF);
    chk("t1_valid", out_valid, 1);
    chk("t1_value", out_value, 16'h0123);
    chk("t1_entry_clr", entry, 0);
    chk("t1_count_clr", digit_count, 0);
    chk("t1_no_reject", last_rj, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t1_valid_drop", out_valid, 0);
    chk("t1_value_hold", out_value, 16'h0123);
    @(negedge clk);
    out_ready = 1'b0;

    // T2 overflow
    press_key(4'h9);
    press_key(4'h8);
    press_key(4'h7);
    press_key(4'h6);
    chk("t2_no_ov4", last_ov, 0);
    chk("t2_entry4", entry, 16'h9876);
    press_key(4'h5);
    chk("t2_ov5", last_ov, 1);
    chk("t2_ev5", last_ev, 1);
    chk("t2_entry5", entry, 16'h9876);
    chk("t2_count5", digit_count, 4);
    @(posedge clk); #1;
    chk("t2_ov_one_cycle", overflow, 0);
    @(negedge clk);
    press_key(4'hE);
    chk("t2_clear", entry, 0);

    // T3 edit keys
    press_key(4'h4);
    chk("t3_a", entry, 16'h0004);
    press_key(4'h5);
    chk("t3_b", entry, 16'h0045);
    press_key(4'hC);
    chk("t3_c", entry, 16'h0004);
    chk("t3_c_count", digit_count, 1);
    press_key(4'h7);
    chk("t3_d", entry, 16'h0047);
    press_key(4'hE);
    chk("t3_e", entry, 16'h0000);
    chk("t3_e_count", digit_count, 0);
    press_key(4'hC);
    chk("t3_f", entry, 16'h0000);
    chk("t3_f_count", digit_count, 0);
    chk("t3_f_no_reject", last_rj, 0);
    chk("t3_f_ev", last_ev, 1);

    // T4 long hold gives one event
    key_value   = 4'h1;
    key_pressed = 1'b1;
    ev_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      ev_cnt += int'(key_event);
    end
    chk("t4_hold_events", ev_cnt, 1);
    chk("t4_hold_entry", entry, 16'h0001);
    @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
    press_key(4'hE);

    // T4 key held across reset deassertion
    key_value   = 4'h2;
    key_pressed = 1'b1;
    reset       = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ev_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      ev_cnt += int'(key_event);
    end
    chk("t4_rst_events", ev_cnt, 0);
    chk("t4_rst_entry", entry, 0);
    @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
    press_key(4'h2);
    chk("t4_repress_ev", last_ev, 1);
    chk("t4_repress_entry", entry, 16'h0002);
    press_key(4'hE);

    // T5 backpressure and type-ahead
    press_key(4'h1);
    press_key(4'h2);
    press_key(4'hF);
    chk("t5_valid", out_valid, 1);
    chk("t5_value", out_value, 16'h0012);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_value !== 16'h0012) bad++;
    end
    chk("t5_stable_50", bad, 0);
    @(negedge clk);
    press_key(4'h3);
    press_key(4'h4);
    chk("t5_typeahead", entry, 16'h0034);
    chk("t5_typeahead_count", digit_count, 2);
    press_key(4'hF);
    chk("t5_f_reject", last_rj, 1);
    chk("t5_f_value", out_value, 16'h0012);
    chk("t5_f_valid", out_valid, 1);
    chk("t5_f_entry", entry, 16'h0034);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_handshake", out_valid, 0);
    @(negedge clk);
    // back in ENTRY: F now commits the type-ahead number
    press_key(4'hF);
    chk("t5_commit2_rj", last_rj, 0);
    chk("t5_commit2_value", out_value, 16'h0034);
    chk("t5_commit2_valid", out_valid, 0);
    out_ready = 1'b0;

    // F in the same cycle as the handshake is rejected
    press_key(4'h5);
    press_key(4'hF);
    chk("sim_valid", out_valid, 1);
    chk("sim_value", out_value, 16'h0005);
    out_ready = 1'b1;
    press_key(4'hF);
    chk("sim_f_reject", last_rj, 1);
    chk("sim_valid_drop", out_valid, 0);
    chk("sim_value_hold", out_value, 16'h0005);
    out_ready = 1'b0;

    // T6 unmapped keys and empty commit
    rj_cnt = 0;
    press_key(4'hA);
    rj_cnt += int'(last_rj);
    press_key(4'hB);
    rj_cnt += int'(last_rj);
    press_key(4'hD);
    rj_cnt += int'(last_rj);
    chk("t6_entry", entry, 0);
    press_key(4'hF);
    rj_cnt += int'(last_rj);
    chk("t6_rejects", rj_cnt, 4);
    chk("t6_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("t6_rj_one_cycle", reject, 0);
    @(negedge clk);

    // Asynchronous reset while a number is pending
    press_key(4'h7);
    press_key(4'hF);
    press_key(4'h8);
    chk("ar_pending", {out_valid, entry}, {1'b1, 16'h0008});
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_value", out_value, 0);
    chk("ar_entry", entry, 0);
    chk("ar_count", digit_count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    press_key(4'h9);
    chk("ar_after_entry", entry, 16'h0009);
    chk("ar_after_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
